// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the clearable byte/bit-enable RAM.
// Latency: n/a (package). Backpressure: n/a.
// Contents: sequencer state enum, lane-count helper, lane-divisibility check.
package ram_pkg;

  // Two-state sequencer: sweeping the array, or serving user accesses.
  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  // Number of write-enable lanes in a data word.
  function automatic int lane_cnt(input int data_len, input int lane_len);
    return data_len / lane_len;
  endfunction

  // True when the data word splits into whole lanes.
  function automatic bit lanes_ok(input int data_len, input int lane_len);
    return (lane_len > 0) && ((data_len % lane_len) == 0);
  endfunction

endpackage

// File: rtl/ram_be_core.sv
// ram_be_core: bare single-port array with per-lane write and registered read.
// Latency: read data registered on the enabled edge after the request.
// Backpressure: none; the clock enable freezes the array and the read register.
//
// Ports:
//   clk     clock
//   en      clock enable; nothing changes when low
//   addr    word address
//   wdata   write data
//   wr_lane per-lane write enable
//   rd      read request; rdata updates only on enabled read cycles
//   rdata   registered read word (holds between reads)
//
// No reset and no output masking: the wrapper qualifies rdata with its own
// valid flag, so undefined contents are never presented.
module ram_be_core #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  input  logic [(DW/LW)-1:0]  wr_lane,
  input  logic                rd,
  output logic [DW-1:0]       rdata
);

  localparam int NLanes = DW / LW;
  localparam int Depth  = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // Array write: only enabled lanes are touched.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < NLanes; l++) begin
        if (wr_lane[l]) begin
          mem[addr][l*LW +: LW] <= wdata[l*LW +: LW];
        end
      end
    end
  end

  // Read port. On a same-cycle write to the same word, enabled lanes forward
  // the incoming data and disabled lanes return the stored contents, so the
  // result equals the word as it looks after the write.
  always_ff @(posedge clk) begin
    if (en && rd) begin
      for (int l = 0; l < NLanes; l++) begin
        rdata[l*LW +: LW] <= wr_lane[l] ? wdata[l*LW +: LW]
                                        : mem[addr][l*LW +: LW];
      end
    end
  end

endmodule

// File: rtl/ram_be_clr.sv
// ram_be_clr: single-port lane-enable RAM with hardware clear sweep after reset
// or on request, busy status and valid-qualified read data.
// Latency: 1 enabled cycle read (2 with RAM_OUTREG_EN); sweep = 2**CAddrLen enabled cycles.
// Backpressure: none; AClkHEn=0 freezes all state, ABusy=1 means user accesses are dropped.
//
// Ports:
//   AClkH    clock
//   AReset   synchronous active-high reset (restarts the sweep)
//   AClkHEn  clock enable for all state including the sweep
//   AAddr    word address
//   AMosi    write data
//   AWrEn    per-lane write enable; any bit set makes a write cycle
//   ARdEn    read request
//   AMiso    read data, zero whenever AValid is low
//   AValid   AMiso carries read data
//   AClrReq  level-sampled request to start a clear sweep (honoured in RUN)
//   ABusy    clear sweep in progress
//
// Build option: define RAM_OUTREG_EN to add a reset-cleared output register
// after the masking stage (read latency 2, sweep timing unchanged).
module ram_be_clr
  import ram_pkg::*;
#(
  parameter int                  CAddrLen  = 8,
  parameter int                  CDataLen  = 16,
  parameter int                  CLaneLen  = 8,
  parameter logic [CDataLen-1:0] CClrValue = '0
) (
  input  logic                                   AClkH,
  input  logic                                   AReset,
  input  logic                                   AClkHEn,
  input  logic [CAddrLen-1:0]                    AAddr,
  input  logic [CDataLen-1:0]                    AMosi,
  input  logic [lane_cnt(CDataLen, CLaneLen)-1:0] AWrEn,
  input  logic                                   ARdEn,
  output logic [CDataLen-1:0]                    AMiso,
  output logic                                   AValid,
  input  logic                                   AClrReq,
  output logic                                   ABusy
);

  localparam int NLanes = lane_cnt(CDataLen, CLaneLen);

  if (!lanes_ok(CDataLen, CLaneLen)) begin : g_lane_chk
    $error("ram_be_clr: CDataLen must be a multiple of CLaneLen");
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e              state_q;
  state_e              state_d;
  logic [CAddrLen-1:0] sweep_addr;
  logic                sweep_last;
  logic                busy;

  assign sweep_last = (sweep_addr == {CAddrLen{1'b1}});

  always_ff @(posedge AClkH) begin
    if (AReset) begin
      state_q <= ST_CLR;
    end else if (AClkHEn) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLR:  if (sweep_last) state_d = ST_RUN;
      ST_RUN:  if (AClrReq)    state_d = ST_CLR;
      default: state_d = ST_CLR;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CLR);
  end

  // Sweep address wraps to 0 after the last word, so a finished sweep leaves
  // it ready for the next request; a request in RUN also forces it to 0.
  always_ff @(posedge AClkH) begin
    if (AReset) begin
      sweep_addr <= '0;
    end else if (AClkHEn) begin
      if (busy) begin
        sweep_addr <= sweep_addr + CAddrLen'(1);
      end else if (AClrReq) begin
        sweep_addr <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array access muxing: the sweep owns the port while busy
  // ---------------------------------------------------------------------------
  logic [CAddrLen-1:0] core_addr;
  logic [CDataLen-1:0] core_wdata;
  logic [NLanes-1:0]   core_wr;
  logic                core_rd;
  logic [CDataLen-1:0] core_rdata;

  always_comb begin
    core_addr  = busy ? sweep_addr : AAddr;
    core_wdata = busy ? CClrValue  : AMosi;
    core_wr    = busy ? {NLanes{1'b1}} : AWrEn;
    core_rd    = !busy && ARdEn;
  end

  ram_be_core #(
    .AW (CAddrLen),
    .DW (CDataLen),
    .LW (CLaneLen)
  ) u_core (
    .clk     (AClkH),
    .en      (AClkHEn),
    .addr    (core_addr),
    .wdata   (core_wdata),
    .wr_lane (core_wr),
    .rd      (core_rd),
    .rdata   (core_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read-valid tracking and output masking
  // ---------------------------------------------------------------------------
  // A read issued in the same cycle as a clear request is still valid on the
  // first CLR cycle; the next enabled edge in CLR clears the flag.
  logic                rd_vld;
  logic [CDataLen-1:0] masked_dat;

  always_ff @(posedge AClkH) begin
    if (AReset) begin
      rd_vld <= 1'b0;
    end else if (AClkHEn) begin
      rd_vld <= core_rd;
    end
  end

  // The core read register has no reset; masking keeps its contents hidden
  // until a real read lands in it.
  assign masked_dat = rd_vld ? core_rdata : '0;

`ifdef RAM_OUTREG_EN
  logic                out_vld;
  logic [CDataLen-1:0] out_dat;

  always_ff @(posedge AClkH) begin
    if (AReset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (AClkHEn) begin
      out_vld <= rd_vld;
      out_dat <= masked_dat;
    end
  end

  assign AValid = out_vld;
  assign AMiso  = out_dat;
`else
  assign AValid = rd_vld;
  assign AMiso  = masked_dat;
`endif

  assign ABusy = busy;

endmodule

// File: tb/tb_ram_be_clr.sv
module tb_ram_be_clr;

  localparam int          AW    = 4;
  localparam int          DW    = 16;
  localparam int          NL    = 2;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CLRV  = 16'hA5A5;

  logic          AClkH = 1'b0;
  logic          AReset;
  logic          AClkHEn;
  logic [AW-1:0] AAddr;
  logic [DW-1:0] AMosi;
  logic [NL-1:0] AWrEn;
  logic          ARdEn;
  logic [DW-1:0] AMiso;
  logic          AValid;
  logic          AClrReq;
  logic          ABusy;

  always #5 AClkH = ~AClkH;

  ram_be_clr #(
    .CAddrLen  (AW),
    .CDataLen  (DW),
    .CLaneLen  (8),
    .CClrValue (CLRV)
  ) dut (
    .AClkH   (AClkH),
    .AReset  (AReset),
    .AClkHEn (AClkHEn),
    .AAddr   (AAddr),
    .AMosi   (AMosi),
    .AWrEn   (AWrEn),
    .ARdEn   (ARdEn),
    .AMiso   (AMiso),
    .AValid  (AValid),
    .AClrReq (AClrReq),
    .ABusy   (ABusy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, clearing flag, sweep position and the
  // read results of the last two enabled edges.
  logic [15:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_sw;
  bit          m_v1, m_v2;
  logic [15:0] m_d1, m_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input logic [3:0] a,
                            input logic [15:0] d, input logic [1:0] we,
                            input bit rd, input bit clr);
    if (rst) begin
      m_busy = 1; m_sw = 0;
      m_v1 = 0; m_d1 = '0; m_v2 = 0; m_d2 = '0;
    end else if (en) begin
      m_v2 = m_v1;
      m_d2 = m_v1 ? m_d1 : 16'h0;
      if (m_busy) begin
        m_mem[m_sw] = CLRV;
        if (m_sw == DEPTH - 1) m_busy = 0;
        m_sw = (m_sw + 1) % DEPTH;
        m_v1 = 0; m_d1 = '0;
      end else begin
        for (int l = 0; l < NL; l++)
          if (we[l]) m_mem[a][l*8 +: 8] = d[l*8 +: 8];
        // Same-cycle read sees the word as it is after the write.
        m_v1 = rd;
        m_d1 = rd ? m_mem[a] : 16'h0;
        if (clr) begin
          m_busy = 1; m_sw = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy", ABusy, m_busy);
`ifdef RAM_OUTREG_EN
    chk("valid", AValid, m_v2);
    chk("miso", AMiso, m_d2);
`else
    chk("valid", AValid, m_v1);
    chk("miso", AMiso, m_v1 ? m_d1 : 16'h0);
`endif
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] we,
                     input bit rd, input bit clr);
    AReset = rst; AClkHEn = en; AAddr = a; AMosi = d;
    AWrEn = we; ARdEn = rd; AClrReq = clr;
    @(posedge AClkH);
    model_step(rst, en, a, d, we, rd, clr);
    @(negedge AClkH);
    check_outputs();
  endtask

  task automatic idle();
    cyc(0, 1, 4'h0, 16'h0, 2'b00, 0, 0);
  endtask

  // Read one word and compare it at the point it appears on the outputs.
  task automatic read_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    cyc(0, 1, a, 16'h0, 2'b00, 1, 0);
`ifdef RAM_OUTREG_EN
    idle();
`endif
    chk(name, AMiso, exp);
    chk({name, "_vld"}, AValid, 1);
  endtask

  // Random accesses on every cycle of a sweep; count enabled busy cycles.
  task automatic run_sweep(input string name, input bit gaps, output int n);
    int g = 0;
    int guard = 0;
    n = 0;
    while (ABusy && guard < 200) begin
      if (gaps && n == 5 && g < 3) begin
        cyc(0, 0, 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        chk({name, "_hold"}, ABusy, 1);
        g++;
      end else begin
        cyc(0, 1, 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        n++;
      end
      guard++;
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  we;
    logic        rd;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int   n;
    int   guard;

    AReset = 1; AClkHEn = 1; AAddr = '0; AMosi = '0;
    AWrEn = '0; ARdEn = 0; AClrReq = 0;

    // Reset state
    cyc(1, 1, 4'h0, 16'h0, 2'b00, 0, 0);
    cyc(1, 1, 4'h3, 16'hFFFF, 2'b11, 1, 1);
    chk("rst_busy", ABusy, 1);
    chk("rst_valid", AValid, 0);
    chk("rst_miso", AMiso, 16'h0);

    // First sweep with ignored accesses and a 3-cycle enable gap
    run_sweep("sweep1", 1, n);
    chk("sweep1_len", n, 16);

    for (int a = 0; a < DEPTH; a++) read_chk("sweep1_val", 4'(a), CLRV);
    idle();
    chk("rd_off_valid", AValid, 0);
    chk("rd_off_miso", AMiso, 16'h0);

    // Directed lane-write and read-during-write vectors
    tbl[0] = '{"wr_full",  4'd3, 16'h1234, 2'b11, 1'b0, 16'h0};
    tbl[1] = '{"wr_lane0", 4'd3, 16'hFFFF, 2'b01, 1'b0, 16'h0};
    tbl[2] = '{"rd_merge", 4'd3, 16'h0000, 2'b00, 1'b1, 16'h12FF};
    tbl[3] = '{"wr_zero",  4'd5, 16'h0000, 2'b11, 1'b0, 16'h0};
    tbl[4] = '{"rdw_lane", 4'd5, 16'hBEEF, 2'b10, 1'b1, 16'hBE00};
    tbl[5] = '{"rdw_full", 4'd7, 16'hC3D2, 2'b11, 1'b1, 16'hC3D2};
    tbl[6] = '{"rd_other", 4'd4, 16'h0000, 2'b00, 1'b1, 16'hA5A5};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].rd, 0);
      if (tbl[i].rd) begin
`ifdef RAM_OUTREG_EN
        idle();
`endif
        chk(tbl[i].name, AMiso, tbl[i].exp);
        chk({tbl[i].name, "_vld"}, AValid, 1);
        idle();
        idle();
        chk({tbl[i].name, "_off"}, AValid, 0);
      end
    end

    // Clock-enable freeze holds the read result
    read_chk("frz_rd", 4'd3, 16'h12FF);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 4'd5, 16'h9999, 2'b11, 1, 1);
      chk("frz_miso", AMiso, 16'h12FF);
      chk("frz_vld", AValid, 1);
    end
    read_chk("frz_nowr", 4'd5, 16'hBE00);

    // Randomised traffic, occasional clear requests and resets
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
          4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
          $urandom_range(0, 63) == 0);
    end
    guard = 0;
    while (ABusy && guard < 100) begin
      idle();
      guard++;
    end
    chk("rand_settle", ABusy, 0);

    // Clear request with a write+read in the same cycle, then reset at sweep addr 7
    cyc(0, 1, 4'd2, 16'h5555, 2'b11, 1, 1);
    chk("clrreq_busy", ABusy, 1);
`ifndef RAM_OUTREG_EN
    chk("clrreq_rd", AMiso, 16'h5555);
    chk("clrreq_vld", AValid, 1);
`endif
    guard = 0;
    while (m_sw != 7 && guard < 50) begin
      cyc(0, 1, 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      guard++;
    end
    chk("reach_addr7", ABusy, 1);
    cyc(1, 1, 4'd2, 16'h1111, 2'b11, 1, 0);
    chk("rst_mid_busy", ABusy, 1);
    run_sweep("sweep2", 0, n);
    chk("sweep2_len", n, 16);
    for (int a = 0; a < DEPTH; a++) read_chk("sweep2_val", 4'(a), CLRV);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
